// File: rtl/wave_gen_param_if.sv
// wave_gen_param_if: control and sample bus of the parametrised waveform generator.
//   master : drives enable, sync, mode, phase_inc, hold, atten; observes the sample outputs
//   slave  : the generator; consumes the controls and drives data_out, valid_out, wrap_out
//   enable    run; low freezes divider and phase
//   sync      synchronous phase/divider restart
//   mode      0 sine, 1 square, 2 triangle, 3 sawtooth
//   phase_inc tuning word added to phase per sample
//   hold      sample period is hold+1 clocks
//   atten     arithmetic right shift applied to the shaped sample
//   data_out  current signed sample (WIDTH bits)
//   valid_out one-cycle pulse when data_out updates
//   wrap_out  one-cycle pulse when the phase accumulator carries out
interface wave_gen_param_if #(
  parameter int WIDTH   = 16,
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 8
);
  logic                      enable;
  logic                      sync;
  logic [1:0]                mode;
  logic [PHASE_W-1:0]        phase_inc;
  logic [DIV_W-1:0]          hold;
  logic [2:0]                atten;
  logic signed [WIDTH-1:0]   data_out;
  logic                      valid_out;
  logic                      wrap_out;

  modport master (
    output enable, sync, mode, phase_inc, hold, atten,
    input  data_out, valid_out, wrap_out
  );

  modport slave (
    input  enable, sync, mode, phase_inc, hold, atten,
    output data_out, valid_out, wrap_out
  );
endinterface

// File: rtl/wave_gen_param.sv
// wave_gen_param: phase-accumulator waveform generator with sample-hold divider,
// four shapes (sine, square, triangle, sawtooth), binary attenuation and output
// width scaling. All outputs are registered.
// Ports:
//   clk    system clock, rising edge
//   rst_in asynchronous active-high reset
//   bus    wave_gen_param_if.slave (controls in, data_out/valid_out/wrap_out out)
module wave_gen_param #(
  parameter int WIDTH   = 16,
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 8
) (
  input  logic            clk,
  input  logic            rst_in,
  wave_gen_param_if.slave bus
);

  // Shift amounts clamped so the unused direction is always a zero shift.
  localparam int SHL = (WIDTH >= 16) ? WIDTH - 16 : 0;
  localparam int SHR = (WIDTH < 16) ? 16 - WIDTH : 0;

  function automatic logic signed [15:0] shape(input logic [1:0] m, input logic [15:0] p);
    logic [15:0] t;
    logic [15:0] r;
    t = {p[14:0], 1'b0};
    case (m)
      2'd0: begin
        case (p[15:13])
          3'd0:    r = 16'h0000;
          3'd1:    r = 16'h5A7E;
          3'd2:    r = 16'h7FFF;
          3'd3:    r = 16'h5A7E;
          3'd4:    r = 16'h0000;
          3'd5:    r = 16'hA582;
          3'd6:    r = 16'h8000;
          default: r = 16'hA582;
        endcase
      end
      2'd1:    r = p[15] ? 16'h8000 : 16'h7FFF;
      // Folding the doubled phase gives a rising then falling ramp; flipping
      // the MSB recentres the unsigned ramp onto the signed range.
      2'd2:    r = (p[15] ? ~t : t) ^ 16'h8000;
      default: r = p ^ 16'h8000;
    endcase
    return signed'(r);
  endfunction

  function automatic logic signed [15:0] attenuate(input logic signed [15:0] s, input logic [2:0] a);
    return s >>> a;
  endfunction

  function automatic logic signed [WIDTH-1:0] scale(input logic signed [15:0] s);
    if (WIDTH >= 16) return WIDTH'(s) <<< SHL;
    else             return WIDTH'(s >>> SHR);
  endfunction

  logic [PHASE_W-1:0]      phase_p0;
  logic [DIV_W-1:0]        cnt_p0;
  logic [PHASE_W:0]        sum_p0;
  logic                    tick_p0;
  logic signed [WIDTH-1:0] data_p1;
  logic                    vld_p1;
  logic                    wrap_p1;

  // Stage p0: phase accumulator and sample-hold divider.
  // The >= compare lets a lowered hold fire on the next enabled cycle.
  assign sum_p0  = {1'b0, phase_p0} + {1'b0, bus.phase_inc};
  assign tick_p0 = (cnt_p0 >= bus.hold);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      phase_p0 <= '0;
      cnt_p0   <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      wrap_p1  <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      wrap_p1 <= 1'b0;
      if (bus.sync) begin
        phase_p0 <= '0;
        cnt_p0   <= '0;
      end else if (bus.enable) begin
        if (tick_p0) begin
          cnt_p0   <= '0;
          // Stage p1: shaped sample from the pre-increment phase.
          data_p1  <= scale(attenuate(shape(bus.mode, phase_p0[PHASE_W-1 -: 16]), bus.atten));
          phase_p0 <= sum_p0[PHASE_W-1:0];
          wrap_p1  <= sum_p0[PHASE_W];
          vld_p1   <= 1'b1;
        end else begin
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = data_p1;
  assign bus.valid_out = vld_p1;
  assign bus.wrap_out  = wrap_p1;

endmodule

// File: tb/tb_wave_gen_param.sv
// tb_wave_gen_param: drives three generator instances (WIDTH 16, 12, 20) from one
// set of controls and compares them every cycle against a behavioural model,
// plus a table of known sample sequences and hand-written timing sequences.
module tb_wave_gen_param;
  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  logic        enable, sync;
  logic [1:0]  mode;
  logic [15:0] phase_inc;
  logic [7:0]  hold;
  logic [2:0]  atten;

  wave_gen_param_if #(.WIDTH(16), .PHASE_W(16), .DIV_W(8)) b16 ();
  wave_gen_param_if #(.WIDTH(12), .PHASE_W(16), .DIV_W(8)) b12 ();
  wave_gen_param_if #(.WIDTH(20), .PHASE_W(16), .DIV_W(8)) b20 ();

  assign b16.enable = enable;  assign b16.sync = sync;  assign b16.mode = mode;
  assign b16.phase_inc = phase_inc;  assign b16.hold = hold;  assign b16.atten = atten;
  assign b12.enable = enable;  assign b12.sync = sync;  assign b12.mode = mode;
  assign b12.phase_inc = phase_inc;  assign b12.hold = hold;  assign b12.atten = atten;
  assign b20.enable = enable;  assign b20.sync = sync;  assign b20.mode = mode;
  assign b20.phase_inc = phase_inc;  assign b20.hold = hold;  assign b20.atten = atten;

  wave_gen_param #(.WIDTH(16), .PHASE_W(16), .DIV_W(8)) dut16 (.clk(clk), .rst_in(rst_in), .bus(b16));
  wave_gen_param #(.WIDTH(12), .PHASE_W(16), .DIV_W(8)) dut12 (.clk(clk), .rst_in(rst_in), .bus(b12));
  wave_gen_param #(.WIDTH(20), .PHASE_W(16), .DIV_W(8)) dut20 (.clk(clk), .rst_in(rst_in), .bus(b20));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int sine_tab [8] = '{0, 23166, 32767, 23166, 0, -23166, -32768, -23166};
  int m_phase, m_since, m_data, m_vld, m_wrap;

  function automatic int ref_shape(input int m, input int p);
    int t;
    case (m)
      0: return sine_tab[p / 8192];
      1: return (p < 32768) ? 32767 : -32768;
      2: begin
        t = (p < 32768) ? 2 * p : 65535 - ((2 * p) % 65536);
        return t - 32768;
      end
      default: return p - 32768;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_since = 0; m_data = 0; m_vld = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int sum;
    m_vld = 0; m_wrap = 0;
    if (sync) begin
      m_phase = 0; m_since = 0;
    end else if (enable) begin
      if (m_since >= int'(hold)) begin
        m_since = 0;
        m_data  = ref_shape(int'(mode), m_phase) >>> int'(atten);
        sum     = m_phase + int'(phase_inc);
        m_wrap  = (sum >= 65536) ? 1 : 0;
        m_phase = sum % 65536;
        m_vld   = 1;
      end else begin
        m_since = m_since + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("data16", $signed(b16.data_out), m_data);
    chk("data12", $signed(b12.data_out), m_data >>> 4);
    chk("data20", $signed(b20.data_out), m_data * 16);
    chk("valid16", int'(b16.valid_out), m_vld);
    chk("wrap16", int'(b16.wrap_out), m_wrap);
    chk("valid12", int'(b12.valid_out), m_vld);
    chk("valid20", int'(b20.valid_out), m_vld);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!b16.valid_out && n < 60);
    if (!b16.valid_out) chk("valid_timeout", 0, 1);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] inc;
    logic [7:0]  hold;
    logic [2:0]  atten;
    logic [15:0] seq [8];
    logic [7:0]  wr;
  } vec_t;

  vec_t vt [4];

  initial begin
    int n;
    vt[0] = '{mode: 2'd0, inc: 16'h2000, hold: 8'd4, atten: 3'd0, wr: 8'h80,
              seq: '{16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E, 16'h0000, 16'hA582, 16'h8000, 16'hA582}};
    vt[1] = '{mode: 2'd2, inc: 16'h4000, hold: 8'd0, atten: 3'd0, wr: 8'h88,
              seq: '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF}};
    vt[2] = '{mode: 2'd3, inc: 16'h8000, hold: 8'd1, atten: 3'd0, wr: 8'hAA,
              seq: '{16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000}};
    vt[3] = '{mode: 2'd1, inc: 16'h8000, hold: 8'd2, atten: 3'd3, wr: 8'hAA,
              seq: '{16'h0FFF, 16'hF000, 16'h0FFF, 16'hF000, 16'h0FFF, 16'hF000, 16'h0FFF, 16'hF000}};

    // Reset state and first-sample latency (legacy settings, hold 4).
    rst_in = 1'b1; enable = 1'b1; sync = 1'b0; mode = 2'd0;
    phase_inc = 16'h2000; hold = 8'd4; atten = 3'd0;
    model_reset();
    #12;
    chk("rst_data", $signed(b16.data_out), 0);
    chk("rst_valid", int'(b16.valid_out), 0);
    chk("rst_wrap", int'(b16.wrap_out), 0);
    rst_in = 1'b0;
    wait_valid(n);
    chk("first_latency", n, 5);
    chk("first_data", int'(b16.data_out), 0);

    // Table of known sequences, each started from a sync restart.
    for (int v = 0; v < 4; v++) begin
      mode = vt[v].mode; phase_inc = vt[v].inc; hold = vt[v].hold; atten = vt[v].atten;
      sync = 1'b1;
      cycle();
      chk("sync_no_valid", int'(b16.valid_out), 0);
      sync = 1'b0;
      for (int k = 0; k < 8; k++) begin
        wait_valid(n);
        chk($sformatf("vec%0d_gap%0d", v, k), n, int'(vt[v].hold) + 1);
        chk($sformatf("vec%0d_data%0d", v, k), {16'h0, b16.data_out}, {16'h0, vt[v].seq[k]});
        chk($sformatf("vec%0d_wrap%0d", v, k), int'(b16.wrap_out), int'(vt[v].wr[k]));
      end
    end

    // Sync mid-period on the legacy sine.
    mode = 2'd0; phase_inc = 16'h2000; hold = 8'd4; atten = 3'd0;
    wait_valid(n); wait_valid(n); wait_valid(n);
    cycle(); cycle();
    sync = 1'b1;
    cycle();
    chk("midsync_no_valid", int'(b16.valid_out), 0);
    sync = 1'b0;
    wait_valid(n);
    chk("midsync_gap", n, 5);
    chk("midsync_data", int'(b16.data_out), 0);

    // Enable low for 7 cycles shifts the next strobe by 7.
    wait_valid(n);
    cycle(); cycle();
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("freeze_no_valid", int'(b16.valid_out), 0);
    end
    enable = 1'b1;
    wait_valid(n);
    chk("freeze_gap", n + 9, 12);

    // Hold lowered below the current count.
    hold = 8'd10;
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    hold = 8'd3;
    cycle();
    chk("lowhold_immediate", int'(b16.valid_out), 1);
    wait_valid(n);
    chk("lowhold_gap1", n, 4);
    wait_valid(n);
    chk("lowhold_gap2", n, 4);

    // Width scaling of sine peaks.
    mode = 2'd0; phase_inc = 16'h2000; hold = 8'd0; atten = 3'd0;
    sync = 1'b1;
    cycle();
    sync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_valid(n);
      if (k == 2) begin
        chk("w16_peak", {16'h0, b16.data_out}, 32'h7FFF);
        chk("w12_peak", {20'h0, b12.data_out}, 32'h7FF);
        chk("w20_peak", {12'h0, b20.data_out}, 32'h7FFF0);
      end
      if (k == 5) begin
        chk("w16_neg", {16'h0, b16.data_out}, 32'hA582);
        chk("w12_neg", {20'h0, b12.data_out}, 32'hA58);
      end
    end

    // Asynchronous reset between edges, mid-run.
    hold = 8'd1;
    wait_valid(n);
    #3;
    rst_in = 1'b1;
    #1;
    chk("async_rst_data16", $signed(b16.data_out), 0);
    chk("async_rst_data20", $signed(b20.data_out), 0);
    chk("async_rst_valid", int'(b16.valid_out), 0);
    chk("async_rst_wrap", int'(b16.wrap_out), 0);
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    rst_in = 1'b0;

    // Randomised controls against the reference model.
    for (int k = 0; k < 600; k++) begin
      sync      = ($urandom_range(0, 24) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      mode      = 2'($urandom_range(0, 3));
      phase_inc = 16'($urandom);
      atten     = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) hold = 8'($urandom_range(0, 5));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/wave_gen_param.md
# wave_gen_param

Parametrised multi-mode waveform generator, successor to the fixed 8-sample sine source. It uses a phase accumulator with a programmable frequency tuning word, a programmable sample-hold divider, and four waveform shapes (sine, square, triangle, sawtooth). It also provides binary attenuation, a phase-sync input, and output width scaling. Output is a registered signed sample with a one-cycle `valid_out` strobe, feeding the audio/DSP datapath.

## Interface
- `WIDTH`, 16: output sample width; legal range 8..24.
- `PHASE_W`, 16: phase accumulator width; must be ≥ 16.
- `DIV_W`, 8: width of the sample-hold divider.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_in`  in  1  reset: asynchronous, active-high.
- `enable`  in  1  run; low freezes divider and phase.
- `sync`  in  1  synchronous phase/divider restart.
- `mode`  in  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- `phase_inc`  in  PHASE_W  tuning word added to phase per sample.
- `hold`  in  DIV_W  sample period is hold+1 clocks.
- `atten`  in  3  arithmetic right shift applied to the shaped sample.
- `data_out`  out  WIDTH signed  current sample.
- `valid_out`  out  1  one-cycle pulse when `data_out` updates.
- `wrap_out`  out  1  one-cycle pulse when the phase accumulator carries out.

## Operation
- **Reset state:** `phase`=0, `cnt`=0, `data_out`=0, `valid_out`=0, `wrap_out`=0. This state applies immediately on `rst_in` high, at any point, including mid-sample.
- **Priority, per cycle:** `sync`, then `enable`, then divider.
- **`sync`=1:**
  - `phase`←0, `cnt`←0.
  - No tick; `valid_out`=0 and `wrap_out`=0 that cycle.
  - `data_out` holds.
- **`enable`=0:**
  - `cnt` and `phase` hold; `data_out` holds.
  - `valid_out` and `wrap_out` are 0.
- **Divider (enable=1):**
  - If `cnt` ≥ `hold`: `cnt`←0 and a tick occurs; else `cnt`←`cnt`+1.
  - The ≥ comparison covers `hold` being lowered below the current `cnt`: the tick occurs on the next enabled cycle.
  - `hold`=0 gives a tick every cycle.
- **On tick:**
  - `data_out` ← scaled(shape(`phase`)), using the current (pre-increment) phase, plus `mode` and `atten` sampled at this cycle.
  - `phase` ← (`phase` + `phase_inc`) mod 2^PHASE_W.
  - `wrap_out`←1 if the addition carries out.
  - `valid_out`←1.
- **Shaping**, on p = top 16 bits of `phase`, producing a 16-bit signed value s:
  - Sine: LUT[p[15:13]] = 0x0000, 0x5A7E, 0x7FFF, 0x5A7E, 0x0000, 0xA582, 0x8000, 0xA582.
  - Square: p[15]=0 → 0x7FFF, else 0x8000.
  - Triangle: t = p[15] ? ~(p<<1) : (p<<1), truncated to 16 bits; s = t ^ 0x8000.
  - Sawtooth: s = p ^ 0x8000.
- **Attenuation:** s ← s >>> `atten` (sign-preserving).
- **Width scaling:**
  - WIDTH ≥ 16: s <<< (WIDTH−16), zero fill.
  - WIDTH < 16: s >>> (16−WIDTH), truncated.
- Mid-run changes to `mode`, `atten` and `phase_inc` take effect at the next tick only; no glitch between ticks.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- **First sample:** with `enable`=1 from reset release and `hold`=H, the first `valid_out` is visible after rising edge H+1 following deassertion. Subsequent strobes come every H+1 edges.
- **Strobe alignment:** `valid_out`, `wrap_out` and the new `data_out` change on the same edge. The strobes are high for exactly one cycle.
- **`sync` restart:** after `sync`, the next tick is H+1 enabled cycles later and outputs shape(phase 0).
- **Freezing:** deasserting `enable` for N cycles delays every subsequent tick by exactly N cycles.
- **Legacy equivalence:** `mode`=0, `phase_inc`=0x2000 (PHASE_W=16), `hold`=4 reproduces the fixed 8-sample sine. Each sample is held 5 clocks; the period is 40 clocks.

## Test plan
- **Legacy sine.** WIDTH=16, mode 0, inc 0x2000, hold 4, atten 0 → `valid_out` every 5 clocks. `data_out` sequence 0000, 5A7E, 7FFF, 5A7E, 0000, A582, 8000, A582, repeating. `wrap_out` pulses with each A582 at phase 0xE000.
- **Triangle and sawtooth.**
  - Triangle, hold 0, inc 0x4000 → `valid_out` every clock; sequence 8000, 0000, 7FFF, FFFF, repeating.
  - Sawtooth, inc 0x8000 → 8000, 0000 alternating.
- **Square with attenuation.** Square, atten 3, inc 0x8000 → 0FFF, F000 alternating.
- **`sync` and `enable`.**
  - Assert `sync` mid-period → no strobe that cycle; the next strobe arrives hold+1 cycles later with phase-0 value (sine 0000).
  - `enable` low for 7 cycles → outputs frozen and strobes shifted by 7.
- **Hold lowered below count.** With hold 10 and `cnt`=6, set hold to 3 → tick on the next clock, then every 4 clocks.
- **Reset and width scaling.**
  - Assert `rst_in` asynchronously between edges mid-run → all outputs 0 immediately.
  - WIDTH=12, sine → 7FFF maps to 7FF and A582 maps to A58.
  - WIDTH=20 → 7FFF maps to 7FFF0.
